// File: rtl/sprite_renderer.sv
// Sprite renderer: maps DrawX/DrawY onto a positioned, scaled, optionally mirrored
// sprite, issues the ROM read and emits a palette index plus opaque-pixel hit flag.
// Latency ROM_LAT+2 cycles, 1 px/clk; update port stalls (upd_ready=0) while a commit is pending.
// Ports: vga_clk/reset_n; DrawX/DrawY/blank/frame_start from the VGA controller;
//        upd_valid/upd_ready + pos_x/pos_y/scale/hflip/enable update request;
//        rom_address/rom_q to the sprite ROM; pix_idx/pix_hit to the colour mapper.
module sprite_renderer #(
  parameter int SPR_W      = 40,
  parameter int SPR_H      = 50,
  parameter int ADDR_W     = 11,
  parameter int IDX_W      = 4,
  parameter int COORD_W    = 10,
  parameter int SCALE_W    = 2,
  parameter int ROM_LAT    = 1,
  parameter int TRANSP_IDX = 0
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               blank,
  input  logic               frame_start,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [SCALE_W-1:0] scale,
  input  logic               hflip,
  input  logic               enable,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pix_idx,
  output logic               pix_hit
);

  // The largest magnified sprite must fit in the coordinate range, so the
  // unsigned box compares below never overflow; the ROM must hold every texel.
  if (((SPR_W << (2**SCALE_W - 1)) >= (1 << COORD_W)) ||
      ((SPR_H << (2**SCALE_W - 1)) >= (1 << COORD_W))) begin : g_bad_coord
    $error("sprite_renderer: magnified sprite does not fit in COORD_W");
  end
  if ((SPR_W * SPR_H - 1) >= (1 << ADDR_W)) begin : g_bad_addr
    $error("sprite_renderer: ADDR_W too small for SPR_W*SPR_H");
  end
  if (ROM_LAT < 1) begin : g_bad_lat
    $error("sprite_renderer: ROM_LAT must be >= 1");
  end

  // Shadow (requested) and active (in use this frame) sprite parameters
  logic               pending_q, pending_d;
  logic [COORD_W-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
  logic [SCALE_W-1:0] sh_sc_q, sh_sc_d;
  logic               sh_hf_q, sh_hf_d, sh_en_q, sh_en_d;
  logic [COORD_W-1:0] ac_x_q, ac_x_d, ac_y_q, ac_y_d;
  logic [SCALE_W-1:0] ac_sc_q, ac_sc_d;
  logic               ac_hf_q, ac_hf_d, ac_en_q, ac_en_d;

  // Pixel pipeline
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [ROM_LAT:0]   inb_q, inb_d;     // [0] aligned with rom_address, [ROM_LAT] with rom_q
  logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
  logic               pix_hit_q, pix_hit_d;

  // Stage 0 combinational terms
  logic signed [COORD_W:0] dx, dy;
  logic [COORD_W-1:0]      w_lim, h_lim, sx, sy;
  logic                    inbox;
  logic                    upd_hs, commit;

  assign upd_ready = ~pending_q;
  assign upd_hs    = upd_valid & ~pending_q;
  // A handshake needs pending=0 and a commit needs pending=1, so they never coincide.
  assign commit    = frame_start & pending_q;

  always_comb begin
    pending_d = pending_q;
    sh_x_d  = sh_x_q;  sh_y_d  = sh_y_q;  sh_sc_d = sh_sc_q;
    sh_hf_d = sh_hf_q; sh_en_d = sh_en_q;
    ac_x_d  = ac_x_q;  ac_y_d  = ac_y_q;  ac_sc_d = ac_sc_q;
    ac_hf_d = ac_hf_q; ac_en_d = ac_en_q;
    if (upd_hs) begin
      sh_x_d  = pos_x;  sh_y_d  = pos_y;  sh_sc_d = scale;
      sh_hf_d = hflip;  sh_en_d = enable;
      pending_d = 1'b1;
    end
    if (commit) begin
      ac_x_d  = sh_x_q;  ac_y_d  = sh_y_q;  ac_sc_d = sh_sc_q;
      ac_hf_d = sh_hf_q; ac_en_d = sh_en_q;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    // One extra sign bit: a pixel left of / above the sprite goes negative
    // instead of wrapping, which is what clips at the screen edges.
    dx    = $signed({1'b0, DrawX}) - $signed({1'b0, ac_x_q});
    dy    = $signed({1'b0, DrawY}) - $signed({1'b0, ac_y_q});
    w_lim = COORD_W'(SPR_W) << ac_sc_q;
    h_lim = COORD_W'(SPR_H) << ac_sc_q;
    inbox = ac_en_q & blank & ~dx[COORD_W] & ~dy[COORD_W] &
            (dx[COORD_W-1:0] < w_lim) & (dy[COORD_W-1:0] < h_lim);
    sx = dx[COORD_W-1:0] >> ac_sc_q;
    sy = dy[COORD_W-1:0] >> ac_sc_q;
    if (ac_hf_q) begin
      sx = COORD_W'(SPR_W - 1) - sx;
    end
    rom_addr_d = inbox ? (ADDR_W'(sy) * ADDR_W'(SPR_W) + ADDR_W'(sx)) : '0;
    inb_d      = {inb_q[ROM_LAT-1:0], inbox};
  end

  always_comb begin
    pix_hit_d = inb_q[ROM_LAT] & (rom_q != IDX_W'(TRANSP_IDX));
    pix_idx_d = pix_hit_d ? rom_q : '0;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= 1'b0;
      sh_x_q     <= '0;   sh_y_q  <= '0;   sh_sc_q <= '0;
      sh_hf_q    <= 1'b0; sh_en_q <= 1'b0;
      ac_x_q     <= '0;   ac_y_q  <= '0;   ac_sc_q <= '0;
      ac_hf_q    <= 1'b0; ac_en_q <= 1'b0;
      rom_addr_q <= '0;
      inb_q      <= '0;
      pix_idx_q  <= '0;
      pix_hit_q  <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      sh_x_q     <= sh_x_d;  sh_y_q  <= sh_y_d;  sh_sc_q <= sh_sc_d;
      sh_hf_q    <= sh_hf_d; sh_en_q <= sh_en_d;
      ac_x_q     <= ac_x_d;  ac_y_q  <= ac_y_d;  ac_sc_q <= ac_sc_d;
      ac_hf_q    <= ac_hf_d; ac_en_q <= ac_en_d;
      rom_addr_q <= rom_addr_d;
      inb_q      <= inb_d;
      pix_idx_q  <= pix_idx_d;
      pix_hit_q  <= pix_hit_d;
    end
  end

  assign rom_address = rom_addr_q;
  assign pix_idx     = pix_idx_q;
  assign pix_hit     = pix_hit_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: reference model plus scoreboard queues for the
// ROM address (1 cycle) and pixel outputs (3 cycles, ROM_LAT=1).
// Inputs driven on negedge; outputs checked on negedge.
module tb_sprite_renderer;
  localparam int CW = 10;
  localparam int AW = 11;
  localparam int IW = 4;
  localparam int SW = 2;

  logic          vga_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CW-1:0] DrawX = '0, DrawY = '0;
  logic          blank = 1'b0, frame_start = 1'b0, upd_valid = 1'b0;
  logic          upd_ready;
  logic [CW-1:0] pos_x = '0, pos_y = '0;
  logic [SW-1:0] scale = '0;
  logic          hflip = 1'b0, enable = 1'b0;
  logic [AW-1:0] rom_address;
  logic [IW-1:0] rom_q = '0;
  logic [IW-1:0] pix_idx;
  logic          pix_hit;

  sprite_renderer dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .pos_x(pos_x), .pos_y(pos_y), .scale(scale),
    .hflip(hflip), .enable(enable), .rom_address(rom_address), .rom_q(rom_q),
    .pix_idx(pix_idx), .pix_hit(pix_hit)
  );

  always #5 vga_clk = ~vga_clk;

  // Sprite ROM contents: texel 5 is transparent, others are nonzero
  function automatic logic [IW-1:0] rom_val(input int a);
    if (a == 5) return '0;
    return IW'((a % 15) + 1);
  endfunction

  always @(posedge vga_clk) rom_q <= rom_val(int'(rom_address));

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Reference model state
  int m_ax = 0, m_ay = 0, m_sc = 0;
  bit m_hf = 0, m_en = 0, m_pend = 0;
  int s_ax = 0, s_ay = 0, s_sc = 0;
  bit s_hf = 0, s_en = 0;
  // Update request fields presented when upd_valid is driven
  int u_x = 0, u_y = 0, u_sc = 0;
  bit u_hf = 0, u_en = 0;

  int aq[$];
  bit hq[$];
  int iq[$];

  task automatic model_reset();
    m_ax = 0; m_ay = 0; m_sc = 0; m_hf = 0; m_en = 0; m_pend = 0;
    s_ax = 0; s_ay = 0; s_sc = 0; s_hf = 0; s_en = 0;
    aq.delete(); hq.delete(); iq.delete();
  endtask

  task automatic step(input int x, input int y, input bit bl = 1'b1,
                      input bit fs = 1'b0, input bit uv = 1'b0);
    int dx, dy, sx, sy, a, v;
    bit inb, hit;
    @(negedge vga_clk);
    if (aq.size() > 0) chk("rom_address", rom_address, aq.pop_front());
    if (hq.size() >= 3) begin
      chk("pix_hit", pix_hit, hq.pop_front());
      chk("pix_idx", pix_idx, iq.pop_front());
    end
    chk("upd_ready", upd_ready, !m_pend);
    DrawX = CW'(x); DrawY = CW'(y); blank = bl; frame_start = fs; upd_valid = uv;
    pos_x = CW'(u_x); pos_y = CW'(u_y); scale = SW'(u_sc); hflip = u_hf; enable = u_en;
    dx  = x - m_ax;
    dy  = y - m_ay;
    inb = m_en && bl && dx >= 0 && dy >= 0 && dx < (40 << m_sc) && dy < (50 << m_sc);
    sx  = dx >> m_sc;
    sy  = dy >> m_sc;
    if (m_hf) sx = 39 - sx;
    a   = inb ? sy * 40 + sx : 0;
    v   = int'(rom_val(a));
    hit = inb && v != 0;
    aq.push_back(a);
    hq.push_back(hit);
    iq.push_back(hit ? v : 0);
    if (fs && m_pend) begin
      m_ax = s_ax; m_ay = s_ay; m_sc = s_sc; m_hf = s_hf; m_en = s_en; m_pend = 0;
    end else if (uv && !m_pend) begin
      s_ax = u_x; s_ay = u_y; s_sc = u_sc; s_hf = u_hf; s_en = u_en; m_pend = 1;
    end
  endtask

  task automatic upd(input int x, input int y, input int sc, input bit hf, input bit en);
    u_x = x; u_y = y; u_sc = sc; u_hf = hf; u_en = en;
    step(0, 0, 1'b0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_addr", rom_address, 0);
    chk("rst_hit", pix_hit, 0);
    chk("rst_idx", pix_idx, 0);
    @(negedge vga_clk);
    reset_n = 1'b1;

    // Basic position, scale 0
    upd(100, 200, 0, 0, 1);
    step(100, 200); step(139, 200); step(140, 200); step(99, 200);
    step(100, 249); step(100, 250); step(139, 249);

    // Scale 1
    upd(100, 200, 1, 0, 1);
    step(103, 205); step(180, 200); step(179, 299); step(179, 300);

    // Horizontal mirror
    upd(100, 200, 0, 1, 1);
    step(100, 200); step(139, 200); step(101, 201);

    // Transparent texel and blanking
    upd(100, 200, 0, 0, 1);
    step(105, 200); step(101, 200, 1'b0); step(106, 200);

    // Pending update: old position persists, second request ignored
    u_x = 300; u_y = 100;
    step(100, 200, 1'b1, 1'b0, 1'b1);
    step(100, 200);
    u_x = 500; u_y = 400;
    step(100, 200, 1'b1, 1'b0, 1'b1);
    step(300, 100);
    step(100, 200, 1'b1, 1'b1, 1'b0);
    step(300, 100); step(100, 200); step(500, 400);

    // Handshake coinciding with frame_start only loads the shadow
    u_x = 600; u_y = 50;
    step(600, 50, 1'b1, 1'b1, 1'b1);
    step(600, 50); step(300, 100);
    step(600, 50, 1'b1, 1'b1, 1'b0);
    step(600, 50); step(300, 100);

    // Clipping at the right edge, no wrap-around; max scale
    upd(1000, 10, 0, 0, 1);
    step(1023, 10); step(5, 10); step(0, 10); step(1023, 59);
    upd(0, 0, 3, 1, 1);
    step(319, 399); step(320, 0); step(0, 400); step(8, 8);
    upd(0, 0, 0, 0, 0);
    step(0, 0); step(10, 10);

    // Random pixels with occasional updates and frame starts
    for (int i = 0; i < 400; i++) begin
      int x, y;
      bit uv, fs;
      uv = ($urandom_range(0, 7) == 0);
      fs = ($urandom_range(0, 15) == 0);
      if (uv) begin
        u_x = int'($urandom_range(0, 1023)); u_y = int'($urandom_range(0, 1023));
        u_sc = int'($urandom_range(0, 3)); u_hf = 1'($urandom_range(0, 1));
        u_en = ($urandom_range(0, 5) != 0);
      end
      x = m_ax + int'($urandom_range(0, 360)) - 20;
      y = m_ay + int'($urandom_range(0, 440)) - 20;
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      if (y < 0) y = 0;
      if (y > 1023) y = 1023;
      step(x, y, ($urandom_range(0, 9) != 0), fs, uv);
    end
    repeat (3) step(0, 0, 1'b0);

    // Reset asserted mid-line while the sprite is being drawn
    upd(100, 200, 0, 0, 1);
    step(100, 200); step(101, 200); step(102, 200);
    @(posedge vga_clk);
    #1;
    chk("pre_rst_hit", pix_hit, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_hit", pix_hit, 0);
    chk("mid_rst_idx", pix_idx, 0);
    chk("mid_rst_addr", rom_address, 0);
    chk("mid_rst_rdy", upd_ready, 1);
    model_reset();
    @(negedge vga_clk);
    reset_n = 1'b1;
    step(100, 200); step(101, 200); step(102, 200); step(103, 200);
    upd(100, 200, 0, 0, 1);
    step(100, 200); step(110, 210);
    repeat (4) step(0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
